// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters; result registered.
// 1-cycle latency; all req_ready held low while an unaccepted result sits in the output register.
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_aluop,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [3:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_res,
    output logic [IDW-1:0]       rsp_id
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] win;
    logic           win_vld;
    logic           can_accept;
    logic           hs;

    assign can_accept = !rsp_valid || rsp_ready;
    assign hs         = win_vld && can_accept;

    // Scan starts just after the last winner and wraps, giving round-robin priority.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win     = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = hs && (win == IDW'(i));
        end
    end

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (win_vld) begin
            alu_op = req_aluop[int'(win)*4 +: 4];
            alu_a  = req_a[int'(win)*32 +: 32];
            alu_b  = req_b[int'(win)*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_id    <= '0;
            last      <= IDW'(NREQ - 1);
        end else if (hs) begin
            rsp_valid <= 1'b1;
            rsp_res   <= alu_res;
            rsp_id    <= win;
            last      <= win;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: NREQ=2 and NREQ=4 instances, each beside a small ALU model.
module tb_alu_share_arb;

    logic clk;
    logic rst_n;

    // NREQ=2 instance
    logic [1:0]   r2_valid, r2_ready;
    logic [7:0]   r2_op;
    logic [63:0]  r2_a, r2_b;
    logic [3:0]   a2_op;
    logic [31:0]  a2_a, a2_b, a2_res;
    logic         s2_valid, s2_ready;
    logic [31:0]  s2_res;
    logic [0:0]   s2_id;

    // NREQ=4 instance
    logic [3:0]   r4_valid, r4_ready;
    logic [15:0]  r4_op;
    logic [127:0] r4_a, r4_b;
    logic [3:0]   a4_op;
    logic [31:0]  a4_a, a4_b, a4_res;
    logic         s4_valid, s4_ready;
    logic [31:0]  s4_res;
    logic [1:0]   s4_id;

    int n_chk;
    int n_err;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign a2_res = alu_model(a2_op, a2_a, a2_b);
    assign a4_res = alu_model(a4_op, a4_a, a4_b);

    alu_share_arb #(.NREQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r2_valid), .req_ready(r2_ready), .req_aluop(r2_op),
        .req_a(r2_a), .req_b(r2_b),
        .alu_op(a2_op), .alu_a(a2_a), .alu_b(a2_b), .alu_res(a2_res),
        .rsp_valid(s2_valid), .rsp_ready(s2_ready), .rsp_res(s2_res), .rsp_id(s2_id)
    );

    alu_share_arb #(.NREQ(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r4_valid), .req_ready(r4_ready), .req_aluop(r4_op),
        .req_a(r4_a), .req_b(r4_b),
        .alu_op(a4_op), .alu_a(a4_a), .alu_b(a4_b), .alu_res(a4_res),
        .rsp_valid(s4_valid), .rsp_ready(s4_ready), .rsp_res(s4_res), .rsp_id(s4_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        r2_valid = '0; r2_op = '0; r2_a = '0; r2_b = '0; s2_ready = 1'b0;
        r4_valid = '0; r4_op = '0; r4_a = '0; r4_b = '0; s4_ready = 1'b0;

        #3;
        chk("rst_valid", 64'(s2_valid), 64'd0);
        chk("rst_res",   64'(s2_res),   64'd0);
        chk("rst_id",    64'(s2_id),    64'd0);
        chk("rst_ready", 64'(r2_ready), 64'd0);
        chk("rst_aluop", 64'(a2_op),    64'd0);
        chk("rst_alua",  64'(a2_a),     64'd0);
        chk("rst_ready4", 64'(r4_ready), 64'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // single requester: ADD 5+7
        r2_valid = 2'b01; r2_op[3:0] = 4'h0; r2_a[31:0] = 32'd5; r2_b[31:0] = 32'd7;
        s2_ready = 1'b1;
        #1;
        chk("single_ready", 64'(r2_ready), 64'b01);
        chk("single_alua",  64'(a2_a),     64'd5);
        chk("single_alub",  64'(a2_b),     64'd7);
        tick;
        r2_valid = 2'b00;
        chk("single_valid", 64'(s2_valid), 64'd1);
        chk("single_res",   64'(s2_res),   64'd12);
        chk("single_id",    64'(s2_id),    64'd0);

        // asynchronous reset while a result is pending
        s2_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(s2_valid), 64'd0);
        chk("arst_res",   64'(s2_res),   64'd0);
        r2_valid = 2'b11;
        r2_op[3:0] = 4'h1; r2_a[31:0] = 32'd10; r2_b[31:0] = 32'd3;
        r2_op[7:4] = 4'h0; r2_a[63:32] = 32'd1; r2_b[63:32] = 32'd1;
        s2_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(r2_ready), 64'b01);

        // fairness: alternating grants, back-to-back responses
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fair_ready%0d", i), 64'(r2_ready), 64'(2'b01 << (i % 2)));
            tick;
            chk($sformatf("fair_valid%0d", i), 64'(s2_valid), 64'd1);
            chk($sformatf("fair_res%0d", i),   64'(s2_res),   (i % 2 == 0) ? 64'd7 : 64'd2);
            chk($sformatf("fair_id%0d", i),    64'(s2_id),    64'(i % 2));
        end

        // load 12 from req0, then backpressure with req1 pending
        r2_valid = 2'b01; r2_op[3:0] = 4'h0; r2_a[31:0] = 32'd5; r2_b[31:0] = 32'd7;
        tick;
        chk("bp_load_res", 64'(s2_res), 64'd12);
        s2_ready = 1'b0;
        r2_valid = 2'b10; r2_op[7:4] = 4'h0; r2_a[63:32] = 32'd2; r2_b[63:32] = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), 64'(r2_ready), 64'b00);
            tick;
            chk($sformatf("bp_res%0d", i),   64'(s2_res),   64'd12);
            chk($sformatf("bp_id%0d", i),    64'(s2_id),    64'd0);
            chk($sformatf("bp_valid%0d", i), 64'(s2_valid), 64'd1);
        end
        s2_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(r2_ready), 64'b10);
        tick;
        chk("bp_release_valid", 64'(s2_valid), 64'd1);
        chk("bp_release_res",   64'(s2_res),   64'd4);
        chk("bp_release_id",    64'(s2_id),    64'd1);

        // unknown opcode passes straight through
        r2_op[7:4] = 4'hA; r2_a[63:32] = 32'h0000_00F0; r2_b[63:32] = 32'h0000_000F;
        #1;
        chk("opc_aluop", 64'(a2_op), 64'hA);
        tick;
        chk("opc_res", 64'(s2_res), 64'hFF);
        chk("opc_id",  64'(s2_id),  64'd1);
        r2_valid = 2'b00;
        #1;
        chk("idle_aluop", 64'(a2_op), 64'd0);
        tick;
        chk("drain_valid", 64'(s2_valid), 64'd0);

        // NREQ=4 wrap-around from last=3 with requesters 1 and 2 valid
        r4_valid = 4'b0110; s4_ready = 1'b1;
        r4_op[7:4]  = 4'h0; r4_a[63:32] = 32'd100; r4_b[63:32] = 32'd1;
        r4_op[11:8] = 4'h0; r4_a[95:64] = 32'd200; r4_b[95:64] = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wrap_ready%0d", i), 64'(r4_ready), (i == 1) ? 64'b0100 : 64'b0010);
            tick;
            chk($sformatf("wrap_id%0d", i),  64'(s4_id),  (i == 1) ? 64'd2 : 64'd1);
            chk($sformatf("wrap_res%0d", i), 64'(s4_res), (i == 1) ? 64'd202 : 64'd101);
        end
        r4_valid = 4'b0000;
        tick;
        chk("wrap_drain", 64'(s4_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and result stage that shares one combinational `alu` instance between `NREQ` requesters, for example two issue lanes or an execute stage plus a branch/address unit.
- Each requester presents an operation with a valid/ready handshake.
- The block steers the winner's operands and `aluop` onto the ALU ports.
- It captures `opr_res` in a single output register and returns it with the winner's index through a valid/ready response channel.
- It sits between decode/issue and writeback, with the ALU instantiated beside it.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2 to 8.
- `IDW`, default `$clog2(NREQ)`: width of the response requester index.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` input, 1: clock.
  - `rst_n` input, 1: reset.
- Request channel, one slice per requester `i`:
  - `req_valid` input, NREQ: request present.
  - `req_ready` output, NREQ: request accepted this cycle.
  - `req_aluop` input, 4*NREQ: `aluop` of requester `i`, in bits `[4i+3:4i]`.
  - `req_a` input, 32*NREQ: operand A of requester `i`.
  - `req_b` input, 32*NREQ: operand B of requester `i`.
- ALU port:
  - `alu_op` output, 4: to ALU `aluop`.
  - `alu_a` output, 32: to ALU `opr_a`.
  - `alu_b` output, 32: to ALU `opr_b`.
  - `alu_res` input, 32: from ALU `opr_res`.
- Response channel:
  - `rsp_valid` output, 1: result held in the output register.
  - `rsp_ready` input, 1: consumer accepts the result.
  - `rsp_res` output, 32: registered ALU result.
  - `rsp_id` output, IDW: index of the requester that produced the result.

## Operation
- **`can_accept`:** `can_accept = !rsp_valid || rsp_ready`.
- **Round-robin pointer:** register `last`, resets to NREQ-1, so requester 0 has first priority.
- **Grant:** at most one grant per cycle.
  - The winner is the first asserted `req_valid[j]`, scanning `j = last+1, last+2, …` modulo NREQ.
  - The scan wraps from NREQ-1 to 0.
- **`req_ready[j]`:** equals `grant[j] && can_accept`; it is 0 for every non-winner.
- **ALU steering:** when any grant exists, `alu_op`/`alu_a`/`alu_b` carry the winner's fields. With no grant they are 0.
- **Handshake on requester j** (`req_valid[j] && req_ready[j]`):
  - `rsp_res` ← `alu_res`, `rsp_id` ← j, `rsp_valid` ← 1, `last` ← j.
- **No handshake:**
  - If `rsp_valid && rsp_ready`, then `rsp_valid` ← 0.
  - Otherwise `rsp_valid`, `rsp_res` and `rsp_id` hold.
- **Simultaneous drain and accept** (`rsp_ready`=1 while `rsp_valid`=1 and a request wins): the new result replaces the old one and `rsp_valid` stays 1. There is no bubble.
- **Requester obligation:** once `req_valid[i]` is asserted, `req_valid[i]`, `req_aluop`, `req_a` and `req_b` slice `i` stay stable until `req_ready[i]`. The block never drops an asserted request.
- **Opcode transparency:** the block does not decode `aluop`. Every 4-bit value passes through unchanged. The result is whatever the ALU returns.
- **Starvation bound:** a continuously valid requester is granted within NREQ handshakes.

## Timing
- **Reset values:**
  - `rsp_valid`=0, `rsp_res`=0, `rsp_id`=0, `last`=NREQ-1.
  - `req_ready` and the ALU outputs follow the combinational rules above; with all `req_valid`=0 they are all 0.
- **Latency:** the result appears on `rsp_res` with `rsp_valid`=1 in the cycle after the request handshake.
- **Throughput:** one operation per cycle while `rsp_ready`=1.
- **Backpressure:** while `rsp_valid`=1 and `rsp_ready`=0:
  - all `req_ready` are 0;
  - `rsp_res` and `rsp_id` stay stable;
  - `last` is unchanged.
- **Arbitration timing:** `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `last`. `rsp_*` outputs are registered only.
- **Reset mid-operation:**
  - `rst_n` low clears `rsp_valid` and `last` immediately, without waiting for a clock edge; a pending response is discarded.
  - The first grant after reset release goes to the lowest-indexed valid requester.

## Test plan
- **Single requester:** NREQ=2; after reset, req0 = ADD (0000), a=5, b=7, `rsp_ready`=1.
  - Required: `req_ready`=01 in that cycle.
  - Next cycle: `rsp_valid`=1, `rsp_res`=12, `rsp_id`=0.
- **Fairness:** both requesters valid for 4 cycles; req0 = SUB (0001) 10−3, req1 = ADD 1+1; `rsp_ready`=1.
  - Required grant order: 0, 1, 0, 1.
  - Required responses: (7,id0), (2,id1), (7,id0), (2,id1), in back-to-back cycles.
- **Backpressure:** hold `rsp_ready`=0 for 3 cycles while req1 (ADD 2+2) is valid and `rsp_valid`=1 with 12.
  - Required: `req_ready`=00 and `rsp_res` stays 12.
  - Raise `rsp_ready`: req1 is granted that cycle; next cycle `rsp_res`=4, id1.
- **Wrap-around:** NREQ=4, `last`=3, requesters 1 and 2 valid.
  - Required: 1 is granted first, then 2, then 1.
  - Required: no grant to an invalid index.
- **Reset mid-operation:** drop `rst_n` while `rsp_valid`=1.
  - Required immediately: `rsp_valid`=0 and `rsp_res`=0.
  - After release with requesters 1 and 0 both valid: requester 0 is granted first.
